// File: rtl/temporal_encoder_n.sv
// Turns a vector of binary time values into temporal-code lanes, one gamma cycle per vector,
// framed by a one-cycle grst pulse; a single pending slot lets frames run back to back.
module temporal_encoder_n #(
  parameter int GAMMA_CYCLE_WIDTH = 16,
  parameter int PULSE_WIDTH       = 8,
  parameter int NUM_OUTPUTS       = GAMMA_CYCLE_WIDTH,
  parameter int VAL_W             = $clog2(GAMMA_CYCLE_WIDTH) + 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [NUM_OUTPUTS*VAL_W-1:0] in_values,
  output logic                         grst,
  output logic [NUM_OUTPUTS-1:0]       y,
  output logic [VAL_W-1:0]             phase,
  output logic                         busy
);

  localparam int               CW     = VAL_W + 1;
  localparam logic [CW-1:0]    G_C    = CW'(GAMMA_CYCLE_WIDTH);
  localparam logic [CW-1:0]    PW_M1  = CW'(PULSE_WIDTH - 1);
  localparam logic [VAL_W-1:0] T_LAST = VAL_W'(GAMMA_CYCLE_WIDTH - 1);
`ifdef FALLING
  localparam logic IDLE_LVL = 1'b1;
`else
  localparam logic IDLE_LVL = 1'b0;
`endif

  typedef enum logic [1:0] {S_IDLE, S_GRST, S_RUN} state_t;

  state_t                       state, state_nx;
  logic [VAL_W-1:0]             t, t_nx;
  logic [NUM_OUTPUTS*VAL_W-1:0] active, active_nx;
  logic [NUM_OUTPUTS*VAL_W-1:0] pending, pending_nx;
  logic                         pending_full, pending_full_nx;
  logic                         xfer;
  logic [NUM_OUTPUTS-1:0]       y_nx;
  logic [CW-1:0]                lane_v, t_ext;

  assign in_ready = !pending_full;
  assign xfer     = in_valid && in_ready;

  always_comb begin
    state_nx        = state;
    t_nx            = t;
    active_nx       = active;
    pending_nx      = pending;
    pending_full_nx = pending_full;
    case (state)
      S_IDLE: begin
        t_nx = '0;
        if (xfer) begin
          active_nx = in_values;
          state_nx  = S_GRST;
        end
      end
      S_GRST: begin
        t_nx     = '0;
        state_nx = S_RUN;
        if (xfer) begin
          pending_nx      = in_values;
          pending_full_nx = 1'b1;
        end
      end
      S_RUN: begin
        if (t == T_LAST) begin
          t_nx = '0;
          // A full pending slot holds in_ready low, so xfer cannot collide with the pending swap.
          if (pending_full) begin
            active_nx       = pending;
            pending_nx      = '0;
            pending_full_nx = 1'b0;
            state_nx        = S_GRST;
          end else if (xfer) begin
            active_nx = in_values;
            state_nx  = S_GRST;
          end else begin
            state_nx = S_IDLE;
          end
        end else begin
          t_nx = t + VAL_W'(1);
          if (xfer) begin
            pending_nx      = in_values;
            pending_full_nx = 1'b1;
          end
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Lane levels are computed for the upcoming cycle so y leaves a flop.
  always_comb begin
    y_nx   = {NUM_OUTPUTS{IDLE_LVL}};
    lane_v = '0;
    t_ext  = {1'b0, t_nx};
    if (state_nx == S_RUN) begin
      for (int i = 0; i < NUM_OUTPUTS; i++) begin
        lane_v = {1'b0, active_nx[i*VAL_W +: VAL_W]};
        if (lane_v < G_C) begin
`ifdef RISING
          y_nx[i] = (t_ext >= lane_v);
`elsif FALLING
          y_nx[i] = (t_ext < lane_v);
`else
          y_nx[i] = (t_ext >= lane_v) && (t_ext <= lane_v + PW_M1);
`endif
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      t            <= '0;
      active       <= '0;
      pending      <= '0;
      pending_full <= 1'b0;
      grst         <= 1'b0;
      busy         <= 1'b0;
      phase        <= '0;
      y            <= {NUM_OUTPUTS{IDLE_LVL}};
    end else begin
      state        <= state_nx;
      t            <= t_nx;
      active       <= active_nx;
      pending      <= pending_nx;
      pending_full <= pending_full_nx;
      grst         <= (state_nx == S_GRST);
      busy         <= (state_nx != S_IDLE);
      phase        <= t_nx;
      y            <= y_nx;
    end
  end

endmodule

// File: tb/tb_temporal_encoder_n.sv
// Directed bench for temporal_encoder_n at G=16, N=4, VAL_W=5, PULSE_WIDTH=8;
// expected lane masks are hand-computed per encoding selected by the same macros.
module tb_temporal_encoder_n;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [19:0]      in_values;
  logic             grst;
  logic [3:0]       y;
  logic [4:0]       phase;
  logic             busy;

  int n_tests = 0;
  int n_fail  = 0;

`ifdef FALLING
  localparam logic [3:0] YL = 4'b1111;
`else
  localparam logic [3:0] YL = 4'b0000;
`endif

  typedef struct packed {
    logic [3:0][4:0]  vals;
    logic [3:0][15:0] mask;
  } vec_t;

  vec_t tbl [3];

  temporal_encoder_n #(
    .GAMMA_CYCLE_WIDTH(16),
    .PULSE_WIDTH(8),
    .NUM_OUTPUTS(4),
    .VAL_W(5)
  ) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_values(in_values),
    .grst(grst),
    .y(y),
    .phase(phase),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // off 0 is the grst cycle, off k (1..16) is RUN step t=k-1.
  task automatic check_frame_cycle(input int off, input logic [3:0][15:0] mask);
    logic [3:0] ey;
    if (off == 0) begin
      chk("grst_high", grst, 1'b1);
      chk("grst_busy", busy, 1'b1);
      chk("grst_y", y, YL);
    end else begin
      for (int l = 0; l < 4; l++) ey[l] = mask[l][off-1];
      chk("run_grst", grst, 1'b0);
      chk("run_busy", busy, 1'b1);
      chk("run_phase", phase, off - 1);
      chk("run_y", y, ey);
    end
  endtask

  task automatic check_idle(input string name);
    chk({name, "_grst"}, grst, 1'b0);
    chk({name, "_busy"}, busy, 1'b0);
    chk({name, "_y"}, y, YL);
    chk({name, "_phase"}, phase, 5'd0);
  endtask

  initial begin
    int ngrst;
    logic exp_rdy;

`ifdef RISING
    tbl[0] = '{vals: {5'd16, 5'd15, 5'd5,  5'd0}, mask: {16'h0000, 16'h8000, 16'hFFE0, 16'hFFFF}};
    tbl[1] = '{vals: {5'd1,  5'd31, 5'd8,  5'd3}, mask: {16'hFFFE, 16'h0000, 16'hFF00, 16'hFFF8}};
    tbl[2] = '{vals: {5'd2,  5'd20, 5'd14, 5'd9}, mask: {16'hFFFC, 16'h0000, 16'hC000, 16'hFE00}};
`elsif FALLING
    tbl[0] = '{vals: {5'd15, 5'd16, 5'd3,  5'd0}, mask: {16'h7FFF, 16'hFFFF, 16'h0007, 16'h0000}};
    tbl[1] = '{vals: {5'd12, 5'd31, 5'd1,  5'd8}, mask: {16'h0FFF, 16'hFFFF, 16'h0001, 16'h00FF}};
    tbl[2] = '{vals: {5'd2,  5'd0,  5'd14, 5'd5}, mask: {16'h0003, 16'h0000, 16'h3FFF, 16'h001F}};
`else
    tbl[0] = '{vals: {5'd20, 5'd15, 5'd10, 5'd0}, mask: {16'h0000, 16'h8000, 16'hFC00, 16'h00FF}};
    tbl[1] = '{vals: {5'd16, 5'd31, 5'd8,  5'd3}, mask: {16'h0000, 16'h0000, 16'hFF00, 16'h07F8}};
    tbl[2] = '{vals: {5'd0,  5'd14, 5'd1,  5'd9}, mask: {16'h00FF, 16'hC000, 16'h01FE, 16'hFE00}};
`endif

    rst = 1'b1;
    in_valid = 1'b0;
    in_values = '0;
    repeat (3) @(negedge clk);
    check_idle("reset");
    chk("reset_in_ready", in_ready, 1'b1);
    rst = 1'b0;

    // Single frames from IDLE, one per table row.
    for (int r = 0; r < 3; r++) begin
      @(negedge clk);
      chk("single_in_ready", in_ready, 1'b1);
      in_valid = 1'b1;
      in_values = tbl[r].vals;
      for (int off = 0; off <= 16; off++) begin
        @(negedge clk);
        in_valid = 1'b0;
        check_frame_cycle(off, tbl[r].mask);
      end
      @(negedge clk);
      check_idle("single_idle");
    end

    // Back-to-back: B lands in pending, C is held until in_ready returns.
    ngrst = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_values = tbl[0].vals;
    for (int c = 0; c < 56; c++) begin
      @(negedge clk);
      if (c < 51) check_frame_cycle(c % 17, tbl[c / 17].mask);
      else check_idle("b2b_idle");
      if (grst) ngrst++;
      exp_rdy = !((c >= 4 && c <= 16) || (c >= 18 && c <= 33));
      chk("b2b_in_ready", in_ready, exp_rdy);
      if (c == 0) in_valid = 1'b0;
      if (c == 3) begin
        in_valid = 1'b1;
        in_values = tbl[1].vals;
      end
      if (c == 4) in_values = tbl[2].vals;
      if (c == 18) in_valid = 1'b0;
    end
    chk("b2b_grst_count", ngrst, 3);

    // Bypass: transfer on the t=15 edge with pending empty.
    @(negedge clk);
    in_valid = 1'b1;
    in_values = tbl[1].vals;
    for (int c = 0; c < 35; c++) begin
      @(negedge clk);
      if (c < 17) check_frame_cycle(c, tbl[1].mask);
      else if (c < 34) check_frame_cycle(c - 17, tbl[2].mask);
      else check_idle("bypass_idle");
      if (c == 0) in_valid = 1'b0;
      if (c == 16) begin
        in_valid = 1'b1;
        in_values = tbl[2].vals;
      end
      if (c == 17) begin
        chk("bypass_in_ready", in_ready, 1'b1);
        in_valid = 1'b0;
      end
    end

    // Reset at t=7 with pending full; the pending vector must never appear.
    @(negedge clk);
    in_valid = 1'b1;
    in_values = tbl[0].vals;
    for (int c = 0; c <= 8; c++) begin
      @(negedge clk);
      check_frame_cycle(c, tbl[0].mask);
      if (c == 0) in_valid = 1'b0;
      if (c == 3) begin
        in_valid = 1'b1;
        in_values = tbl[1].vals;
      end
      if (c == 4) begin
        chk("midrst_pending_full", in_ready, 1'b0);
        in_valid = 1'b0;
      end
    end
    rst = 1'b1;
    @(negedge clk);
    check_idle("midrst");
    chk("midrst_in_ready", in_ready, 1'b1);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // rst and a transfer on the same edge: the vector is dropped.
    rst = 1'b1;
    in_valid = 1'b1;
    in_values = tbl[2].vals;
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0;
    check_idle("rst_xfer");
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      chk("dropped_grst", grst, 1'b0);
      chk("dropped_busy", busy, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/temporal_encoder_n.md
# temporal_encoder_N

- Converts a vector of binary time values into temporal-code lines.
- Each value becomes an event at that time step within a gamma cycle.
- Also generates the `grst` pulse that marks each gamma-cycle boundary.
- Sits at the front of a temporal datapath and drives consumers such as `mux_t_t_t_N` and `equal` that compare edge or pulse timing.

## Interface
- `GAMMA_CYCLE_WIDTH`, default 16: time steps per gamma cycle (G).
- `PULSE_WIDTH`, default 8: event length in cycles, pulse-width encoding only.
- `NUM_OUTPUTS`, default `GAMMA_CYCLE_WIDTH`: number of temporal lanes (N).
- `VAL_W`, default `$clog2(GAMMA_CYCLE_WIDTH)+1`: bits per lane value. Any value ≥ G encodes "no event" (infinity).
- Encoding is selected at compile time, identically to the consumers: `RISING` macro for rising-edge, `FALLING` for falling-edge, neither for pulse-width.
- `clk` in 1: single clock.
- `rst` in 1: synchronous, active-high reset.
- `in_valid` in 1: `in_values` is valid.
- `in_ready` out 1: encoder can accept a vector.
- `in_values` in N*VAL_W: lane i occupies bits `[i*VAL_W +: VAL_W]`.
- `grst` out 1: gamma reset, high for exactly one cycle per frame.
- `y` out N: temporal lines.
- `phase` out VAL_W: current time step t, valid while `busy`.
- `busy` out 1: frame in progress (GRST or RUN).

## Operation
- **Storage:** active register holds the vector being emitted; one pending register buffers the next vector.
- **Handshake:**
  - `in_ready = !pending_full`.
  - A transfer occurs on any edge where `in_valid && in_ready`.
- **Transfer routing:**
  - Loads directly into active and sets state GRST when state is IDLE.
  - Also loads directly into active (no gap) when state is RUN, t=G-1 and pending is empty.
  - Otherwise loads into pending.
- **FSM states:** IDLE, GRST, RUN.
  - IDLE → GRST on a transfer.
  - GRST → RUN after one cycle, with t=0.
  - RUN increments t each cycle.
  - At t=G-1: if pending is full, move pending to active, clear pending, go to GRST. If a bypass transfer occurs, go to GRST. Otherwise go to IDLE.
- **Idle level L:** 0 for rising and pulse encoding, 1 for falling encoding.
- **Lane output in RUN**, with v = lane value:
  - Rising: `y[i]=1` iff t≥v. Stays high until the frame ends.
  - Falling: `y[i]=1` iff t<v.
  - Pulse: `y[i]=1` iff v≤t≤min(v+PULSE_WIDTH-1, G-1). Pulses running past the frame end are truncated.
  - If v≥G, the lane stays at L for the whole RUN.
- **Lane output in GRST and IDLE:** `y=L` on all lanes. `grst=1` only in GRST.
- **Comparison width:** all comparisons are unsigned and VAL_W+1 bits wide, so `v+PULSE_WIDTH-1` never wraps.
- **Reset:** applies in any state, including mid-frame. Next cycle:
  - state IDLE, pending cleared, active cleared, t=0;
  - `grst=0`, `busy=0`, `in_ready=1`, `y=L`, `phase=0`.
- **During a frame:** `in_values` changes have no effect on the frame in progress.

## Timing
- All outputs are registered. There is no combinational path from inputs to outputs except `in_ready` from `pending_full`, which is itself a flop.
- **Latency from IDLE:** with a transfer on edge E0:
  - `grst` is high in cycle E0→E1.
  - t=0 is cycle E1→E2.
  - The lane event for value v begins in cycle E(v+1)→E(v+2).
- **Frame period:** G+1 cycles (1 GRST + G RUN).
- **Back-to-back frames:** follow with no IDLE cycle. Sustained throughput is one vector per G+1 cycles.
- **Backpressure:** while busy with pending full, `in_ready=0`. It returns to 1 the cycle after pending is consumed at t=G-1.
- **Simultaneous rst and transfer:** rst wins, and the vector is dropped.

## Test plan
Configuration for all scenarios: G=16, N=4, VAL_W=5.
- **Rising, single vector:** values {0,5,15,16}, transfer from IDLE.
  - `grst` high 1 cycle.
  - lane0 high from t=0; lane1 from t=5; lane2 only at t=15; lane3 never.
  - IDLE at the 18th cycle after transfer, `y=0`.
- **Falling, single vector:** values {0,3,16,15}.
  - lane0 low all RUN; lane1 high t=0..2; lane2 high all RUN; lane3 high t=0..14.
  - `y=4'b1111` in GRST and IDLE.
- **Pulse, PULSE_WIDTH=8:** values {0,10,15,20}.
  - lane0 high t=0..7; lane1 high t=10..15 (truncated); lane2 high t=15 only; lane3 never.
- **Back-to-back:** second vector sent during frame 1 and third held `in_valid` until `in_ready`.
  - `in_ready=0` after second transfer.
  - Frame 2 `grst` immediately follows frame 1 t=15; frame 3 likewise.
  - Exactly three `grst` pulses, 17 cycles apart.
- **Bypass at boundary:** transfer exactly at the t=15 edge with pending empty → next cycle is GRST with the new vector, no IDLE cycle.
- **Reset mid-frame:** assert rst at t=7 with pending full.
  - Next cycle: `busy=0`, `y=L`, `grst=0`, `in_ready=1`.
  - The pending vector is never emitted.
